// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: word FIFO plus bit shifter.
// Queued words stream out back-to-back with no idle bits.
module seq_serializer #(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  din,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic          msb_first,
   output logic          outbit,
   output logic          out_valid,
   output logic          busy,
   output logic [LW-1:0] level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t        state, state_nx;
   logic [N:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [N-1:0]  shreg;
   logic          ord;
   logic [CW-1:0] cnt;
   logic          push, pop;
   logic          last;

   assign din_ready = (level != LW'(DEPTH));
   assign push      = din_valid && din_ready;
   assign last      = (cnt == CW'(N - 1));

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      unique case (state)
         IDLE: begin
            if (level != '0) begin
               pop      = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               if (level != '0) begin
                  pop = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Storage is not reset; pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= {msb_first, din};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Shift toward whichever end the stored order bit selects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         ord   <= 1'b0;
         cnt   <= '0;
      end else if (pop) begin
         {ord, shreg} <= mem[rptr];
         cnt          <= '0;
      end else if (state == SHIFT) begin
         cnt <= cnt + CW'(1);
         if (ord) begin
            shreg <= {shreg[N-2:0], 1'b0};
         end else begin
            shreg <= {1'b0, shreg[N-1:1]};
         end
      end
   end

   assign out_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);
   assign outbit    = (state == SHIFT) && (ord ? shreg[N-1] : shreg[0]);

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: queue-based reference model,
// directed scenarios followed by random traffic.
module tb_seq_serializer;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  din;
   logic          din_valid;
   logic          din_ready;
   logic          msb_first;
   logic          outbit;
   logic          out_valid;
   logic          busy;
   logic [LW-1:0] level;

   int ncmp = 0;
   int nerr = 0;

   logic [N:0] q[$];
   logic       bits[$];
   logic [31:0] cap;
   int          ncap;
   logic        acc;

   always #5 clk = ~clk;

   seq_serializer #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .din(din),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .msb_first(msb_first),
      .outbit(outbit),
      .out_valid(out_valid),
      .busy(busy),
      .level(level)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic eb;
      eb = (bits.size() > 0) ? bits[0] : 1'b0;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(bits.size() > 0));
      chk({tag, ".busy"}, 32'(busy), 32'(bits.size() > 0));
      chk({tag, ".outbit"}, 32'(outbit), 32'(eb));
      chk({tag, ".level"}, 32'(level), 32'(q.size()));
      chk({tag, ".din_ready"}, 32'(din_ready), 32'(q.size() != DEPTH));
   endtask

   // One clock: drive inputs, advance the model, check after the edge.
   task automatic step(input logic v, input logic [N-1:0] d,
                       input logic m, input string tag);
      logic       pm, pp;
      logic [N:0] w;
      din_valid = v;
      din       = d;
      msb_first = m;
      pm  = v && (q.size() != DEPTH);
      pp  = (q.size() > 0) && (bits.size() <= 1);
      acc = pm;
      @(posedge clk);
      if (bits.size() > 0) void'(bits.pop_front());
      if (pp) begin
         w = q.pop_front();
         for (int i = 0; i < N; i++) begin
            bits.push_back(w[N] ? w[N-1-i] : w[i]);
         end
      end
      if (pm) q.push_back({m, d});
      #1;
      if (out_valid === 1'b1) begin
         cap = {cap[30:0], outbit};
         ncap++;
      end
      chk_all(tag);
   endtask

   task automatic idle_n(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, tag);
   endtask

   task automatic clr_cap();
      cap  = '0;
      ncap = 0;
   endtask

   initial begin
      int hits;
      int lastj;
      int nw;
      logic [N-1:0] win;

      rst_n     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      msb_first = 1'b0;
      clr_cap();
      #12;
      chk_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 4'hA MSB first -> 1,0,1,0
      clr_cap();
      step(1'b1, 4'hA, 1'b1, "a_push");
      chk("a_lat0", 32'(out_valid), 32'd0);
      idle_n(6, "a_run");
      chk("a_bits", cap, 32'hA);
      chk("a_cnt", 32'(ncap), 32'd4);

      // 4'h6 LSB first -> 0,1,1,0
      clr_cap();
      step(1'b1, 4'h6, 1'b0, "b_push");
      step(1'b0, '0, 1'b1, "b_lat1");
      chk("b_first", 32'(out_valid), 32'd1);
      idle_n(5, "b_run");
      chk("b_bits", cap, 32'h6);

      // Two words back-to-back, also fed to a detector model for 4'h6
      clr_cap();
      step(1'b1, 4'hA, 1'b1, "c_push0");
      step(1'b1, 4'h6, 1'b1, "c_push1");
      idle_n(10, "c_run");
      chk("c_bits", cap, 32'hA6);
      chk("c_cnt", 32'(ncap), 32'd8);
      chk("c_level", 32'(level), 32'd0);
      hits  = 0;
      lastj = -1;
      for (int j = 3; j < 8; j++) begin
         win = N'(cap >> (7 - j));
         if (win == 4'h6) begin
            hits++;
            lastj = j;
         end
      end
      chk("det_hits", 32'(hits), 32'd1);
      chk("det_pos", 32'(lastj), 32'd7);

      // Words 1..7 with din_valid held high; fill to DEPTH
      clr_cap();
      nw = 1;
      for (int i = 0; i < 40 && nw <= 7; i++) begin
         step(1'b1, N'(nw), 1'b1, "d_fill");
         if (acc) nw++;
      end
      chk("d_all_pushed", 32'(nw), 32'd8);
      idle_n(40, "d_drain");
      chk("d_bits", cap, 32'h1234567);
      chk("d_cnt", 32'(ncap), 32'd28);

      // Async reset mid-word with two words queued
      step(1'b1, 4'hA, 1'b1, "e_push0");
      step(1'b1, 4'h5, 1'b1, "e_push1");
      step(1'b1, 4'h3, 1'b1, "e_push2");
      step(1'b0, '0, 1'b0, "e_bit1");
      #2;
      rst_n = 1'b0;
      q.delete();
      bits.delete();
      #1;
      chk_all("e_async");
      @(negedge clk);
      rst_n = 1'b1;
      idle_n(6, "e_after");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'b1 & ($urandom_range(0, 2) != 0), N'($urandom),
              1'($urandom), "rnd");
      end
      idle_n(30, "rnd_drain");
      chk("rnd_empty", 32'(level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial front end feeding the shift-register sequence detector's `inbit` input.
- Accepts N-bit words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Emits words one bit per clock on `outbit`, with `out_valid` qualifying each bit.
- Words that are already queued are sent back-to-back with no idle cycles, so the detector sees a gap-free stream.

Parameters:
- N, 4: word width in bits; must match the detector's N.
- DEPTH, 4: FIFO depth in words; power of 2, ≥2.
- LW, $clog2(DEPTH)+1: width of `level`; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  async active-low reset.
- din  input  N  word to enqueue.
- din_valid  input  1  `din` is valid this cycle.
- din_ready  output  1  FIFO can accept; push occurs when `din_valid && din_ready` at the clock edge.
- msb_first  input  1  bit order; sampled per word at push and stored alongside the word.
- outbit  output  1  serial data bit.
- out_valid  output  1  `outbit` carries a live data bit.
- busy  output  1  shifter holds a word in flight.
- level  output  LW  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (`rst_n` low, asynchronous, any time): FIFO pointers and `level` go to 0.
  - State goes to IDLE; bit counter goes to 0.
  - Outputs: `outbit`=0, `out_valid`=0, `busy`=0, `din_ready`=1.
  - A word being shifted is discarded; no partial word resumes after release.
- FIFO:
  - Each entry stores {msb_first, din}.
  - `din_ready` = (`level` != DEPTH), computed from registered state only; no combinational path from `din_valid`.
  - Push when `din_valid && din_ready`; pointers wrap modulo DEPTH.
  - Simultaneous push and pop in one cycle: `level` is unchanged and both take effect.
  - When full, a same-cycle pop does not make room for that cycle's push; the source retries next cycle.
- Shifter FSM:
  - IDLE: `out_valid`=0, `outbit`=0, `busy`=0. If `level`>0, pop the head into the shift register and go to SHIFT; set bit counter to 0.
  - SHIFT: `out_valid`=1, `busy`=1.
    - `outbit` is shreg[N-1] when the stored order bit is 1, else shreg[0].
    - Each edge shifts toward the output end and increments the counter.
    - At counter==N-1: if `level`>0, pop the next word in the same edge and stay in SHIFT with counter=0 (back-to-back). Otherwise go to IDLE.
- Latency: a word pushed at edge k into an empty, idle block has its first bit on `outbit` after edge k+1, and its last bit after edge k+N.
- Bit order is fixed per word at push time; toggling `msb_first` mid-word has no effect on the word in flight.
- All outputs are registered or decoded from registered state.
- `level` is exact after every edge, including edges with simultaneous push and pop.
- Overflow is impossible by construction. Pop is never attempted when `level`==0.

Test Plan:
- Reset, then push 4'hA with `msb_first`=1 → `outbit` = 1,0,1,0 on 4 consecutive cycles with `out_valid`=1; then `out_valid`=0 and `outbit`=0.
- Push 4'h6 with `msb_first`=0 → `outbit` = 0,1,1,0; first bit appears exactly one cycle after the push edge.
- Push 4'hA then 4'h6 on consecutive cycles (both `msb_first`=1) → 8 contiguous bits 1,0,1,0,0,1,1,0 with `out_valid` never dropping; `level` returns to 0.
- Hold `din_valid`=1 with words 1..7 (DEPTH=4) → `din_ready` deasserts exactly when `level`==4; no word lost or duplicated; all 7 words emerge in order, gap-free.
- Assert `rst_n`=0 after the 2nd bit of 4'hA with 2 words queued → outputs drop to reset values asynchronously. After release, `out_valid` stays 0 until a new push; queued words are gone.
- Drive the output into the detector with code=4'h6 and push 4'hA, 4'h6 → detector asserts its match output after the final bit of 4'h6 and never during 4'hA.
